// File: rtl/sd_host_arb_pkg.sv
// Shared types and widths for the two-requester SD host arbiter.
package sd_host_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_REQ = 2;
    localparam int LBA_W   = 32;
    localparam int BADDR_W = 9;

endpackage

// File: rtl/sd_host_arb_rr_arb2.sv
// Two-input round-robin grant: combinational, no state of its own.
module rr_arb2
    import sd_host_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last,
    output logic               o_valid,
    output logic               o_gnt
);

    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    always_comb begin
        o_valid = |i_req;
        o_gnt   = i_req[1] & (~i_req[0] | ~i_last);
    end

endmodule

// File: rtl/sd_host_arb.sv
// Shares one SD host port between two block-level requesters.
// Grants round-robin, forwards the sector transfer to the granted
// requester only, and aborts a transaction that exceeds TIMEOUT cycles.
module sd_host_arb
    import sd_host_arb_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
)(
    input  logic               clk_sys,
    input  logic               res_n,
    input  logic [LBA_W-1:0]   req0_lba,
    input  logic               req0_rd,
    input  logic               req0_wr,
    output logic               req0_ack,
    output logic [BADDR_W-1:0] req0_buff_addr,
    output logic [7:0]         req0_buff_dout,
    output logic               req0_buff_wr,
    input  logic [7:0]         req0_buff_din,
    input  logic [LBA_W-1:0]   req1_lba,
    input  logic               req1_rd,
    input  logic               req1_wr,
    output logic               req1_ack,
    output logic [BADDR_W-1:0] req1_buff_addr,
    output logic [7:0]         req1_buff_dout,
    output logic               req1_buff_wr,
    input  logic [7:0]         req1_buff_din,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    input  logic [BADDR_W-1:0] sd_buff_addr,
    input  logic [7:0]         sd_buff_dout,
    input  logic               sd_buff_wr,
    output logic [7:0]         sd_buff_din,
    output logic               act,
    output logic               err
);

    state_t             r_state;
    logic               r_last;
    logic               r_gnt;
    logic               r_sd_rd;
    logic               r_sd_wr;
    logic               r_err;
    logic [LBA_W-1:0]   r_lba;
    logic [23:0]        r_cnt;

    logic [NUM_REQ-1:0] w_req;
    logic               w_valid;
    logic               w_gnt;
    logic               w_gnt_rd;
    logic               w_gnt_req;
    logic               w_timeout;

    assign w_req     = {req1_rd | req1_wr, req0_rd | req0_wr};
    // rd and wr both high is served as a read
    assign w_gnt_rd  = w_gnt ? req1_rd : req0_rd;
    assign w_gnt_req = r_gnt ? w_req[1] : w_req[0];
    // Counter is 0 on the first ISSUE cycle, so the abort lands TIMEOUT cycles after entry
    assign w_timeout = (r_cnt == TIMEOUT - 24'd1);

    rr_arb2 u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_gnt   (w_gnt)
    );

    // Transaction FSM: grant, issue to host, transfer, one-cycle wrap-up
    always_ff @(posedge clk_sys) begin
        if (!res_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            r_sd_rd <= 1'b0;
            r_sd_wr <= 1'b0;
            r_err   <= 1'b0;
            r_lba   <= '0;
            r_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= w_gnt;
                        r_lba   <= w_gnt ? req1_lba : req0_lba;
                        r_sd_rd <= w_gnt_rd;
                        r_sd_wr <= ~w_gnt_rd;
                        r_cnt   <= '0;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + 24'd1;
                    if (w_timeout) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_err   <= 1'b1;
                        r_last  <= r_gnt;
                        r_state <= ST_IDLE;
                    end else if (sd_ack) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= ST_XFER;
                    end else if (!w_gnt_req) begin
                        // Requester withdrew before the host took it: no ack, no turn used
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    r_cnt <= r_cnt + 24'd1;
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_last  <= r_gnt;
                        r_state <= ST_IDLE;
                    end else if (!sd_ack) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_gnt;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Route the host buffer port to the granted requester during XFER only
    always_comb begin
        req0_ack       = 1'b0;
        req0_buff_addr = '0;
        req0_buff_dout = '0;
        req0_buff_wr   = 1'b0;
        req1_ack       = 1'b0;
        req1_buff_addr = '0;
        req1_buff_dout = '0;
        req1_buff_wr   = 1'b0;
        sd_buff_din    = '0;
        if (r_state == ST_XFER) begin
            if (r_gnt) begin
                req1_ack       = sd_ack;
                req1_buff_addr = sd_buff_addr;
                req1_buff_dout = sd_buff_dout;
                req1_buff_wr   = sd_buff_wr;
                sd_buff_din    = req1_buff_din;
            end else begin
                req0_ack       = sd_ack;
                req0_buff_addr = sd_buff_addr;
                req0_buff_dout = sd_buff_dout;
                req0_buff_wr   = sd_buff_wr;
                sd_buff_din    = req0_buff_din;
            end
        end
    end

    assign sd_lba = r_lba;
    assign sd_rd  = r_sd_rd;
    assign sd_wr  = r_sd_wr;
    assign act    = (r_state != ST_IDLE);
    assign err    = r_err;

endmodule

// File: tb/tb_sd_host_arb.sv
// Randomized bench for sd_host_arb: the bench plays host and both
// requesters and predicts each transaction from a small arbitration model.
module tb_sd_host_arb;

    localparam logic [23:0] TO = 24'd1000;

    logic        clk_sys = 1'b0;
    logic        res_n;
    logic [31:0] req0_lba, req1_lba;
    logic        req0_rd, req0_wr, req1_rd, req1_wr;
    logic        req0_ack, req1_ack, req0_buff_wr, req1_buff_wr;
    logic [8:0]  req0_buff_addr, req1_buff_addr;
    logic [7:0]  req0_buff_dout, req1_buff_dout, req0_buff_din, req1_buff_din;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, sd_buff_din;
    logic        act, err;

    int n_vec  = 0;
    int n_err  = 0;
    int m_last = 1;   // model: requester served most recently

    always #5 clk_sys = ~clk_sys;

    // Each requester answers write data as a keyed function of the address it sees
    assign req0_buff_din = req0_buff_addr[7:0] ^ 8'hA5;
    assign req1_buff_din = req1_buff_addr[7:0] ^ 8'h5A;

    sd_host_arb #(.TIMEOUT(TO)) dut (
        .clk_sys(clk_sys), .res_n(res_n),
        .req0_lba(req0_lba), .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_ack(req0_ack),
        .req0_buff_addr(req0_buff_addr), .req0_buff_dout(req0_buff_dout),
        .req0_buff_wr(req0_buff_wr), .req0_buff_din(req0_buff_din),
        .req1_lba(req1_lba), .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_ack(req1_ack),
        .req1_buff_addr(req1_buff_addr), .req1_buff_dout(req1_buff_dout),
        .req1_buff_wr(req1_buff_wr), .req1_buff_din(req1_buff_din),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .act(act), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic clr_inputs();
        req0_rd = 0; req0_wr = 0; req1_rd = 0; req1_wr = 0;
        req0_lba = 0; req1_lba = 0;
        sd_ack = 0; sd_buff_wr = 0; sd_buff_addr = 0; sd_buff_dout = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        res_n = 0;
        cyc();
        res_n = 1;
        m_last = 1;
    endtask

    // One full transaction from IDLE with requests already presented
    task automatic serve(input int nb, input int dly);
        int w, seen, sw, sl, bad, stray;
        logic r0, r1, exp_rd;
        logic [31:0] exp_lba;
        logic [7:0] key, dv;
        r0 = req0_rd | req0_wr;
        r1 = req1_rd | req1_wr;
        w = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
        exp_rd  = (w == 1) ? req1_rd : req0_rd;
        exp_lba = (w == 1) ? req1_lba : req0_lba;
        key     = (w == 1) ? 8'h5A : 8'hA5;
        sw = 0; sl = 0; bad = 0; stray = 0;
        cyc();
        chk("gnt_sd_rd", 32'(sd_rd), 32'(exp_rd));
        chk("gnt_sd_wr", 32'(sd_wr), 32'(!exp_rd));
        chk("gnt_lba", sd_lba, exp_lba);
        chk("gnt_act", 32'(act), 32'd1);
        chk("gnt_err", 32'(err), 32'd0);
        for (int i = 0; i < dly; i++) begin
            sd_buff_wr = 1;
            #1;
            stray += int'(req0_buff_wr) + int'(req1_buff_wr) + int'(req0_ack) + int'(req1_ack);
            cyc();
        end
        sd_buff_wr = 0;
        chk("issue_hold", 32'(sd_rd | sd_wr), 32'd1);
        sd_ack = 1;
        cyc();
        chk("issue_drop", 32'(sd_rd | sd_wr), 32'd0);
        seen = req1_ack ? 1 : (req0_ack ? 0 : 2);
        chk("winner", 32'(seen), 32'(w));
        if (w == 1) begin req1_rd = 0; req1_wr = 0; end
        else begin req0_rd = 0; req0_wr = 0; end
        for (int i = 0; i < nb; i++) begin
            dv = 8'($urandom);
            sd_buff_addr = 9'(i);
            sd_buff_dout = dv;
            sd_buff_wr   = exp_rd;
            #1;
            if (w == 1) begin
                sw += int'(req1_buff_wr);
                sl += int'(req0_buff_wr);
                if (req1_ack !== 1'b1 || req1_buff_addr !== 9'(i) || req1_buff_dout !== dv ||
                    req0_ack !== 1'b0 || req0_buff_addr !== 9'd0 || req0_buff_dout !== 8'd0) bad++;
            end else begin
                sw += int'(req0_buff_wr);
                sl += int'(req1_buff_wr);
                if (req0_ack !== 1'b1 || req0_buff_addr !== 9'(i) || req0_buff_dout !== dv ||
                    req1_ack !== 1'b0 || req1_buff_addr !== 9'd0 || req1_buff_dout !== 8'd0) bad++;
            end
            if (sd_buff_din !== (8'(i) ^ key)) bad++;
            cyc();
        end
        sd_ack = 0; sd_buff_wr = 0; sd_buff_addr = 0;
        chk("strobes_win", 32'(sw), exp_rd ? 32'(nb) : 32'd0);
        chk("strobes_lose", 32'(sl), 32'd0);
        chk("xfer_route", 32'(bad), 32'd0);
        chk("issue_stray", 32'(stray), 32'd0);
        cyc();
        chk("done_act", 32'(act), 32'd1);
        chk("done_ack", 32'(req0_ack | req1_ack), 32'd0);
        cyc();
        chk("idle_act", 32'(act), 32'd0);
        m_last = w;
    endtask

    initial begin
        int m0, m1, first, n_hi, seen, cnt;
        clr_inputs();
        res_n = 0;
        repeat (2) cyc();
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_ack", 32'(req0_ack | req1_ack), 32'd0);
        chk("rst_bwr", 32'(req0_buff_wr | req1_buff_wr), 32'd0);
        chk("rst_act", 32'(act), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        res_n = 1;
        cyc();

        // Single full-sector read from requester 0
        req0_rd = 1; req0_lba = 32'h1234;
        serve(512, 5);

        // Tie straight after reset: 0, then 1 (write sweep), then 0 wins the next tie
        do_reset();
        req0_lba = $urandom; req1_lba = req0_lba ^ 32'hFFFF_0000;
        req0_rd = 1; req1_wr = 1;
        serve(20, 2);
        serve(512, 1);
        req0_lba = $urandom; req1_lba = req0_lba ^ 32'h00FF_FF00;
        req0_rd = 1; req1_rd = 1;
        serve(8, 0);
        serve(8, 0);

        // Random mixes, including rd+wr together and back-to-back regrants
        for (int it = 0; it < 10; it++) begin
            m0 = $urandom_range(0, 3);
            m1 = $urandom_range(0, 3);
            if (m0 == 0 && m1 == 0) m0 = 3;
            req0_rd = m0[0]; req0_wr = m0[1];
            req1_rd = m1[0]; req1_wr = m1[1];
            req0_lba = $urandom; req1_lba = ~req0_lba;
            serve($urandom_range(1, 40), $urandom_range(0, 6));
            if (req0_rd | req0_wr | req1_rd | req1_wr)
                serve($urandom_range(1, 40), $urandom_range(0, 6));
        end

        // Cancel before host ack; pending requester 1 goes next
        req0_rd = 1; req0_lba = $urandom;
        cyc();
        chk("cx_grant", 32'(sd_rd), 32'd1);
        req1_rd = 1; req1_lba = $urandom;
        seen = 0;
        repeat (2) begin seen |= int'(req0_ack); cyc(); end
        req0_rd = 0;
        #1 seen |= int'(req0_ack);
        cyc();
        chk("cx_sd_rd", 32'(sd_rd), 32'd0);
        chk("cx_act", 32'(act), 32'd0);
        chk("cx_ack", 32'(seen | int'(req0_ack)), 32'd0);
        serve(16, 3);

        // Host never acks: abort after TO cycles, stuck requester then loses the tie
        req0_rd = 1; req0_lba = $urandom;
        cyc();
        first = -1; n_hi = 0;
        for (int k = 1; k <= int'(TO); k++) begin
            cyc();
            if (err) begin
                n_hi++;
                if (first < 0) first = k;
            end
        end
        chk("to_at", 32'(first), 32'(TO));
        chk("to_pulses", 32'(n_hi), 32'd1);
        chk("to_sd_rd", 32'(sd_rd), 32'd0);
        chk("to_act", 32'(act), 32'd0);
        m_last = 0;
        req1_rd = 1; req1_lba = $urandom;
        serve(10, 1);
        serve(10, 1);

        // Reset in the middle of a transfer
        req0_rd = 1; req0_lba = $urandom | 32'h1;
        cyc();
        sd_ack = 1;
        cyc();
        req0_rd = 0;
        for (int i = 0; i < 3; i++) begin
            sd_buff_wr = 1; sd_buff_addr = 9'(i);
            cyc();
        end
        res_n = 0;
        cyc();
        res_n = 1;
        m_last = 1;
        chk("rx_sd_rd", 32'(sd_rd | sd_wr), 32'd0);
        chk("rx_lba", sd_lba, 32'd0);
        chk("rx_ack", 32'(req0_ack | req1_ack), 32'd0);
        chk("rx_bwr", 32'(req0_buff_wr | req1_buff_wr), 32'd0);
        chk("rx_act", 32'(act), 32'd0);
        chk("rx_err", 32'(err), 32'd0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            sd_buff_addr = 9'(i + 3);
            cyc();
            cnt += int'(req0_buff_wr) + int'(req1_buff_wr) + int'(act);
        end
        chk("rx_quiet", 32'(cnt), 32'd0);
        sd_ack = 0; sd_buff_wr = 0; sd_buff_addr = 0;
        cyc();
        req1_rd = 1; req1_lba = $urandom;
        serve(4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
